// File: rtl/exec_sequencer_if.sv
// Control bundle between the instruction sequencer and its datapath/instruction memory.
// The sequencer owns the slave modport; the environment driving it owns the master.
interface exec_sequencer_if;
    logic       start;
    logic       mem_ready;
    logic [2:0] opcode;
    logic       ir_load;
    logic       alu_en;
    logic [1:0] alu_op;
    logic       rf_we;
    logic       pc_en;
    logic       pc_load;
    logic       busy;
    logic       halted;
    logic       fault;
    logic [7:0] instr_count;

    modport slave (
        input  start, mem_ready, opcode,
        output ir_load, alu_en, alu_op, rf_we, pc_en, pc_load, busy, halted, fault, instr_count
    );

    modport master (
        output start, mem_ready, opcode,
        input  ir_load, alu_en, alu_op, rf_we, pc_en, pc_load, busy, halted, fault, instr_count
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with fetch timeout and sticky fault.
// All outputs are registered and decoded from the next state and instruction register.
module exec_sequencer #(
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input logic               clk_i,
    input logic               rst_ni,
    exec_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StWb, StHalt} state_e;

    localparam logic [7:0] TimeoutLast = 8'(FETCH_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [2:0] ir_q, ir_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] count_q, count_d;
    logic       fault_q, fault_d;

    logic       ir_load_q, ir_load_d;
    logic       alu_en_q, alu_en_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       rf_we_q, rf_we_d;
    logic       pc_en_q, pc_en_d;
    logic       pc_load_q, pc_load_d;
    logic       busy_q, busy_d;
    logic       halted_q, halted_d;

    logic       is_alu, is_jmp;
    logic [2:0] ir_m1;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        count_d = count_q;
        fault_d = fault_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFetch;
                    wait_d  = 8'd0;
                end
            end
            StFetch: begin
                // A ready memory wins even on the cycle the wait budget runs out.
                if (bus.mem_ready) begin
                    ir_d    = bus.opcode;
                    state_d = StDecode;
                end else if (wait_q == TimeoutLast) begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDecode: begin
                if (ir_q == 3'b111) begin
                    state_d = StHalt;
                end else if (ir_q == 3'b110) begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: state_d = StWb;
            StWb: begin
                count_d = count_q + 8'd1;
                wait_d  = 8'd0;
                state_d = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        is_alu    = (ir_d != 3'd0) && (ir_d <= 3'd4);
        is_jmp    = (ir_d == 3'd5);
        ir_m1     = ir_d - 3'd1;
        ir_load_d = (state_d == StFetch);
        busy_d    = (state_d == StFetch) || (state_d == StDecode) ||
                    (state_d == StExec) || (state_d == StWb);
        halted_d  = (state_d == StHalt);
        alu_en_d  = (state_d == StExec) && is_alu;
        alu_op_d  = alu_en_d ? ir_m1[1:0] : 2'b00;
        pc_load_d = (state_d == StExec) && is_jmp;
        rf_we_d   = (state_d == StWb) && is_alu;
        pc_en_d   = (state_d == StWb) && !is_jmp;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ir_q      <= 3'd0;
            wait_q    <= 8'd0;
            count_q   <= 8'd0;
            fault_q   <= 1'b0;
            ir_load_q <= 1'b0;
            alu_en_q  <= 1'b0;
            alu_op_q  <= 2'b00;
            rf_we_q   <= 1'b0;
            pc_en_q   <= 1'b0;
            pc_load_q <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            fault_q   <= fault_d;
            ir_load_q <= ir_load_d;
            alu_en_q  <= alu_en_d;
            alu_op_q  <= alu_op_d;
            rf_we_q   <= rf_we_d;
            pc_en_q   <= pc_en_d;
            pc_load_q <= pc_load_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.ir_load     = ir_load_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.pc_en       = pc_en_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed/randomized bench for exec_sequencer; expected outputs come from a per-instruction
// cycle schedule derived from the opcode table, not from the RTL's state machine.
module tb_exec_sequencer;

    localparam int unsigned Timeout = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_count = 8'd0;
    logic       exp_fault = 1'b0;

    exec_sequencer_if bus();

    exec_sequencer #(.FETCH_TIMEOUT(Timeout)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ov(input logic ir_load, input logic alu_en,
                                      input logic [1:0] alu_op, input logic rf_we,
                                      input logic pc_en, input logic pc_load, input logic busy,
                                      input logic halted, input logic fault);
        return {ir_load, alu_en, alu_op, rf_we, pc_en, pc_load, busy, halted, fault};
    endfunction

    function automatic logic [9:0] v_fetch();
        return ov(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_fault);
    endfunction

    function automatic logic [9:0] v_decode();
        return ov(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_fault);
    endfunction

    function automatic logic [9:0] v_halt();
        return ov(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_fault);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [9:0] exp_v);
        logic [9:0] obs;
        obs = {bus.ir_load, bus.alu_en, bus.alu_op, bus.rf_we, bus.pc_en, bus.pc_load,
               bus.busy, bus.halted, bus.fault};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp_v);
        end
        checks++;
        assert (bus.instr_count === exp_count) else begin
            failures++;
            $error("FAIL %s instr_count observed=%0d expected=%0d", tag, bus.instr_count,
                   exp_count);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        exp_count = 8'd0;
        exp_fault = 1'b0;
        check("reset", 10'd0);
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_fetch", v_fetch());
    endtask

    // Entered on the first observed FETCH cycle; leaves on the next FETCH cycle or in HALT.
    task automatic run_instr(input logic [2:0] op, input int unsigned delay);
        logic       alu;
        logic [1:0] aop;
        for (int i = 0; i < int'(delay); i++) begin
            bus.mem_ready = 1'b0;
            bus.opcode    = 3'($urandom);
            step();
            check("fetch_wait", v_fetch());
        end
        bus.mem_ready = 1'b1;
        bus.opcode    = op;
        step();
        bus.mem_ready = 1'($urandom);
        bus.opcode    = 3'($urandom);
        check("decode", v_decode());
        if (op == 3'b111 || op == 3'b110) begin
            if (op == 3'b110) exp_fault = 1'b1;
            step();
            check("halt", v_halt());
            return;
        end
        alu = (op >= 3'd1 && op <= 3'd4);
        case (op)
            3'd1:    aop = 2'b00;
            3'd2:    aop = 2'b01;
            3'd3:    aop = 2'b10;
            3'd4:    aop = 2'b11;
            default: aop = 2'b00;
        endcase
        step();
        check("exec", ov(1'b0, alu, aop, 1'b0, 1'b0, op == 3'd5, 1'b1, 1'b0, exp_fault));
        step();
        check("wb", ov(1'b0, 1'b0, 2'b00, alu, op != 3'd5, 1'b0, 1'b1, 1'b0, exp_fault));
        step();
        exp_count = exp_count + 8'd1;
        check("next_fetch", v_fetch());
    endtask

    task automatic fetch_timeout();
        for (int i = 0; i < int'(Timeout) - 1; i++) begin
            bus.mem_ready = 1'b0;
            step();
            check("timeout_wait", v_fetch());
        end
        bus.mem_ready = 1'b0;
        step();
        exp_fault = 1'b1;
        check("timeout_halt", v_halt());
    endtask

    task automatic start_ignored();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("halt_start_ignored", v_halt());
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = 3'd1;
        step();
        check("reset_overrides_start", 10'd0);
        step();
        check("reset_held", 10'd0);
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_dwell", 10'd0);
        end

        // Single ADD: ir_load cycle 1, ALU cycle 3, writeback cycle 4.
        do_start();
        run_instr(3'd1, 0);

        for (int i = 0; i < 3; i++) run_instr(3'd5, $urandom_range(0, Timeout - 1));
        for (int i = 0; i < 24; i++) begin
            run_instr(3'($urandom_range(0, 5)), $urandom_range(0, 3));
        end

        do_reset();
        do_start();
        run_instr(3'd1, 0);
        run_instr(3'd2, 0);
        run_instr(3'd4, 0);
        run_instr(3'd7, 0);
        start_ignored();

        // Ready arriving on the last allowed FETCH cycle, then a genuine timeout.
        do_reset();
        do_start();
        run_instr(3'd3, Timeout - 1);
        fetch_timeout();
        start_ignored();

        do_reset();
        do_start();
        run_instr(3'd6, $urandom_range(0, 4));
        start_ignored();
        do_reset();

        do_start();
        for (int i = 0; i < 256; i++) run_instr(3'd0, 0);
        bus.mem_ready = 1'b1;
        bus.opcode    = 3'd1;
        step();
        check("wrap_decode", v_decode());
        step();
        check("wrap_exec", ov(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        step();
        check("wrap_wb", ov(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        rst_n = 1'b0;
        step();
        exp_count = 8'd0;
        check("reset_in_wb", 10'd0);
        rst_n = 1'b1;
        step();
        check("idle_after_reset", 10'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter: FETCH_TIMEOUT, default 15, max cycles FETCH waits for mem_ready before faulting (range 1..255).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  one clock; reset is synchronous and active-low.
REQ-004 start  input  1  begin execution from IDLE; ignored in all other states.
REQ-005 mem_ready  input  1  instruction memory output (opcode/operands) valid this cycle.
REQ-006 opcode  input  3  instruction opcode from instruction memory, sampled only in FETCH when mem_ready=1.
REQ-007 ir_load  output  1  latch instruction memory outputs into datapath registers.
REQ-008 alu_en  output  1  ALU enable.
REQ-009 alu_op  output  2  ALU operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-010 rf_we  output  1  register file write enable.
REQ-011 pc_en  output  1  PC increment strobe.
REQ-012 pc_load  output  1  PC load of jump address.
REQ-013 busy  output  1  high in FETCH, DECODE, EXEC, WB.
REQ-014 halted  output  1  high in HALT.
REQ-015 fault  output  1  sticky; illegal opcode or fetch timeout occurred.
REQ-016 instr_count  output  8  retired-instruction counter.

Function
REQ-017 States SHALL be IDLE, FETCH, DECODE, EXEC, WB, HALT; one-state-per-cycle except FETCH and IDLE/HALT dwell.
REQ-018 Opcode map SHALL be: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 JMP, 110 illegal, 111 HLT.
REQ-019 IDLE: start=1 -> FETCH next cycle; else stay.
REQ-020 FETCH: ir_load=1 in every FETCH cycle; when mem_ready=1, opcode SHALL be captured into internal ir register and state -> DECODE.
REQ-021 FETCH wait counter SHALL clear on FETCH entry and increment each cycle mem_ready=0; reaching FETCH_TIMEOUT with mem_ready=0 -> HALT, fault=1.
REQ-022 mem_ready=1 on the same cycle the counter reaches FETCH_TIMEOUT SHALL take priority (capture, -> DECODE, no fault).
REQ-023 DECODE: all strobes 0; ir=111 -> HALT; ir=110 -> HALT with fault=1; otherwise -> EXEC.
REQ-024 EXEC: ALU opcodes assert alu_en=1 with alu_op = ir-1 (2 LSBs); JMP asserts pc_load=1; NOP asserts nothing; -> WB.
REQ-025 WB: ALU opcodes assert rf_we=1; pc_en=1 for all opcodes except JMP; instr_count += 1; -> FETCH.
REQ-026 alu_op SHALL hold 00 whenever alu_en=0.
REQ-027 pc_en and pc_load SHALL never be high in the same cycle.
REQ-028 instr_count SHALL wrap 255 -> 0 without flag; HLT and illegal opcodes are not counted.
REQ-029 HALT: halted=1, all strobes 0; leaves only via reset; start ignored.
REQ-030 All outputs SHALL be decoded from current state and ir only (Moore); no input-to-output combinational path.
REQ-031 Latency: with mem_ready held 1, one instruction SHALL take exactly 4 cycles, start to first ir_load 1 cycle.

Reset
REQ-032 rst=0 at a rising edge SHALL force IDLE, ir=000, wait counter=0, instr_count=0, fault=0, all outputs 0 from that edge, regardless of current state (incl. mid-EXEC or WB).
REQ-033 rst=0 SHALL override start and mem_ready in the same cycle.

Verification
REQ-034 Reset, start pulse, mem_ready=1, opcode=001 -> ir_load cycle 1, alu_en=1 alu_op=00 cycle 3, rf_we=1 pc_en=1 cycle 4, instr_count=1.
REQ-035 Opcode 101 stream -> pc_load=1 in EXEC, pc_en=0 in WB, rf_we never 1, instr_count increments.
REQ-036 mem_ready=0 for 15 cycles in FETCH -> HALT, fault=1, halted=1, instr_count unchanged; variant with mem_ready=1 on the 15th cycle -> DECODE, fault=0.
REQ-037 Program ADD, SUB, OR, HLT -> alu_op 00, 01, 11 in successive EXECs, then halted=1, instr_count=3; start afterwards has no effect.
REQ-038 Opcode 110 -> HALT with fault=1 after DECODE; rst=0 then -> all outputs 0, fault=0, IDLE.
REQ-039 256 NOPs -> instr_count wraps to 0; rst=0 asserted during WB -> no rf_we/pc_en on the following cycle, instr_count=0.
